uart_ram_loader: RTL
====================

Name: uart_ram_loader

Overview:
- Upstream loader stage for the RAM/UART board path. It pulls bytes from the on-board UART through the shared RAM1 data bus and packs byte pairs into little-endian 16-bit words.
- It writes each word into RAM2 at consecutive addresses from a base address, then reports completion.
- Its outputs drive the same RAM2/UART pins the machine switcher multiplexes, and the switcher selects it in its own mode.

Parameters:
- ADDR_W, 18, RAM2 address width.
- RD_WAIT, 2, cycles rdn is held low before the UART byte is sampled (minimum 1).

Ports:
- clk  in  1  system clock (11.0592 MHz domain).
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle, ignored otherwise.
- abort  in  1  synchronous; returns to IDLE from any state.
- base_addr  in  ADDR_W  first RAM2 word address, sampled on start.
- word_count  in  16  number of words to load, sampled on start.
- data_ready  in  1  UART has a received byte.
- uart_data  in  8  RAM1 data bus bits [7:0] (UART read data).
- rdn  out  1  UART read strobe, active low.
- ram1_en, ram1_oe, ram1_we  out  1 each  held at 1 so the UART owns the RAM1 bus.
- ram2_addr  out  ADDR_W  RAM2 address.
- ram2_wdata  out  16  RAM2 write data.
- ram2_drive  out  1  tristate enable for ram2_wdata onto the RAM2 bus.
- ram2_en, ram2_oe, ram2_we  out  1 each  RAM2 controls, active low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- words_written  out  16  words committed in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; rdn=1; ram2_en=1, ram2_oe=1, ram2_we=1; ram2_drive=0.
  - ram2_addr=0, ram2_wdata=0, words_written=0; done=0; busy=0.
  - Internal low-byte register, byte_sel and counters cleared.
- All outputs are registered. ram1_* are constant 1. ram2_oe stays 1 in all states.
- States: IDLE, WAIT_RX, RD_LOW, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE, start=1:
  - If word_count=0: go to DONE (done pulses next cycle, words_written=0).
  - Otherwise: latch base_addr into ram2_addr and word_count into remaining; clear words_written and byte_sel; go to WAIT_RX.
- WAIT_RX:
  - data_ready=1: rdn<=0, go to RD_LOW.
  - data_ready=0: stay.
- RD_LOW: hold rdn=0 for RD_WAIT cycles, then go to RD_LATCH.
- RD_LATCH: sample uart_data and set rdn<=1.
  - byte_sel=0: store the low byte, byte_sel<=1, go to WAIT_RX.
  - byte_sel=1: ram2_wdata<={uart_data, low}, byte_sel<=0, go to WR_SETUP.
- WR_SETUP: ram2_en=0, ram2_drive=1, ram2_we=1; address and data stable. Go to WR_PULSE.
- WR_PULSE: ram2_we=0 for exactly 1 cycle.
- WR_HOLD:
  - ram2_we=1; data still driven.
  - words_written+1; ram2_addr+1, wrapping modulo 2^ADDR_W (3FFFF -> 0).
  - If words_written+1 = word_count: go to DONE, else go to WAIT_RX.
  - ram2_en and ram2_drive return to 1/0 on leaving WR_HOLD.
- DONE: done=1 for one cycle, then IDLE.
- Bytes per word are strictly ordered low then high. A data_ready still high in the cycle after RD_LATCH starts a new read only via WAIT_RX, so there is never a back-to-back strobe without a rdn=1 cycle.
- Busy handling: start while busy is ignored. start and abort in the same cycle in IDLE: abort wins, no load starts.
- abort:
  - Next cycle: IDLE, rdn=1, ram2_we=1, ram2_en=1, ram2_drive=0; done not pulsed.
  - words_written keeps its value.
  - A half-received byte pair is discarded.
- Write cycle timing: exactly 3 clocks (setup/pulse/hold). ram2_addr and ram2_wdata never change while ram2_we=0.
- Per-word latency: 2*(RD_WAIT+2)+3 cycles after data_ready, when data_ready is already high.

Test Plan:
- Reset mid-WR_PULSE (rst low) -> same instant ram2_we=1, ram2_en=1, ram2_drive=0, rdn=1, busy=0.
- base_addr=00010, word_count=2, UART bytes 34,12,CD,AB with data_ready always high -> RAM2[00010]=1234, RAM2[00011]=ABCD, one done pulse, words_written=2, and each ram2_we low exactly 1 cycle.
- word_count=0, start -> done pulse 2 cycles after start, no rdn or ram2_we activity.
- base_addr=3FFFF, word_count=2 -> writes to 3FFFF then 00000.
- abort after the first byte of word 1 (word_count=3) -> IDLE next cycle, no done, words_written=1. A new start then re-syncs on the low byte.
- start pulsed while busy, plus data_ready gaps of 50 cycles between bytes -> second start ignored; rdn only asserts when data_ready=1 and always pulses low for RD_WAIT cycles.

Source files
------------

// File: rtl/uart_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_ram_loader
// Brief    : Reads UART bytes over the RAM1 bus, packs little-endian 16-bit
//            words and writes them to consecutive RAM2 addresses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_ram_loader #(
    parameter int ADDR_W  = 18,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic              data_ready,
    input  logic [7:0]        uart_data,
    output logic              rdn,
    output logic              ram1_en,
    output logic              ram1_oe,
    output logic              ram1_we,
    output logic [ADDR_W-1:0] ram2_addr,
    output logic [15:0]       ram2_wdata,
    output logic              ram2_drive,
    output logic              ram2_en,
    output logic              ram2_oe,
    output logic              ram2_we,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_written
);

    localparam int c_WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RX  = 3'd1,
        S_RD_LOW   = 3'd2,
        S_RD_LATCH = 3'd3,
        S_WR_SETUP = 3'd4,
        S_WR_PULSE = 3'd5,
        S_WR_HOLD  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_byte_sel;
    logic [7:0]          r_low;
    logic [15:0]         r_remaining;
    logic [15:0]         r_words_written;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic                r_rdn;
    logic                r_ram2_en;
    logic                r_ram2_we;
    logic                r_ram2_drive;
    logic                r_busy;
    logic                r_done;
    logic                w_wr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (start) w_next = (word_count == 16'd0) ? S_DONE : S_WAIT_RX;
                S_WAIT_RX:  if (data_ready) w_next = S_RD_LOW;
                S_RD_LOW:   if (r_wait_cnt == c_WAIT_LAST) w_next = S_RD_LATCH;
                S_RD_LATCH: w_next = r_byte_sel ? S_WR_SETUP : S_WAIT_RX;
                S_WR_SETUP: w_next = S_WR_PULSE;
                S_WR_PULSE: w_next = S_WR_HOLD;
                S_WR_HOLD:  w_next = (r_remaining == 16'd1) ? S_DONE : S_WAIT_RX;
                S_DONE:     w_next = S_IDLE;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    assign w_wr_next = (w_next == S_WR_SETUP) || (w_next == S_WR_PULSE) || (w_next == S_WR_HOLD);

    // Strobes are decoded from the next state so every pin is a flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt      <= '0;
            r_byte_sel      <= 1'b0;
            r_low           <= 8'd0;
            r_remaining     <= 16'd0;
            r_words_written <= 16'd0;
            r_addr          <= '0;
            r_wdata         <= 16'd0;
            r_rdn           <= 1'b1;
            r_ram2_en       <= 1'b1;
            r_ram2_we       <= 1'b1;
            r_ram2_drive    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_rdn        <= !((w_next == S_RD_LOW) || (w_next == S_RD_LATCH));
            r_ram2_en    <= !w_wr_next;
            r_ram2_drive <= w_wr_next;
            r_ram2_we    <= (w_next != S_WR_PULSE);
            r_busy       <= (w_next != S_IDLE);
            r_done       <= (r_state == S_DONE) && !abort;
            if (abort) begin
                r_byte_sel <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_words_written <= 16'd0;
                            r_byte_sel      <= 1'b0;
                            if (word_count != 16'd0) begin
                                r_addr      <= base_addr;
                                r_remaining <= word_count;
                            end
                        end
                    end
                    S_WAIT_RX: r_wait_cnt <= '0;
                    S_RD_LOW:  r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    S_RD_LATCH: begin
                        if (!r_byte_sel) begin
                            r_low      <= uart_data;
                            r_byte_sel <= 1'b1;
                        end else begin
                            r_wdata    <= {uart_data, r_low};
                            r_byte_sel <= 1'b0;
                        end
                    end
                    S_WR_HOLD: begin
                        r_words_written <= r_words_written + 16'd1;
                        r_addr          <= r_addr + ADDR_W'(1);
                        r_remaining     <= r_remaining - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rdn           = r_rdn;
    assign ram1_en       = 1'b1;
    assign ram1_oe       = 1'b1;
    assign ram1_we       = 1'b1;
    assign ram2_addr     = r_addr;
    assign ram2_wdata    = r_wdata;
    assign ram2_drive    = r_ram2_drive;
    assign ram2_en       = r_ram2_en;
    assign ram2_oe       = 1'b1;
    assign ram2_we       = r_ram2_we;
    assign busy          = r_busy;
    assign done          = r_done;
    assign words_written = r_words_written;

endmodule
`default_nettype wire
